// File: rtl/quality_inspect_pkg.sv
// Shared encodings for the quality inspection controller: channel verdict
// states, protocol states, protocol output codes and a small popcount helper.
package quality_inspect_pkg;

  // Channel state doubles as the E verdict code for that channel.
  typedef enum logic [1:0] {
    CH_IDLE    = 2'b00,
    CH_INSPECT = 2'b01,
    CH_PASS    = 2'b10,
    CH_REJECT  = 2'b11
  } ch_state_e;

  // Protocol FSM states.
  typedef enum logic [1:0] {
    PR_RUN  = 2'b00,
    PR_WARN = 2'b01,
    PR_STOP = 2'b10
  } prot_state_e;

  // Protocol output codes on Y.
  localparam logic [1:0] Y_RUN     = 2'b00;
  localparam logic [1:0] Y_WARN    = 2'b01;
  localparam logic [1:0] Y_STOP    = 2'b10;
  localparam logic [1:0] Y_RESTART = 2'b11;

  // Width of the per-channel hold and fail counters (limits are at most 15).
  localparam int CTR_W = 4;

  // Number of set bits in an 8-bit vector (channels never exceed 8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/quality_inspect_ctrl_inspect_channel.sv
// One inspection channel: IDLE/INSPECT/PASS/REJECT Moore FSM with its verdict
// hold counter and its saturating consecutive-reject counter.
module inspect_channel
  import quality_inspect_pkg::*;
#(
  parameter int FAIL_LIMIT  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start_ok,   // line running and reset release settled
  input  logic             prod,
  input  logic             ri,
  input  logic             fail_clr,   // operator restart acknowledged this edge
  output logic [1:0]       state,
  output logic             enter_pass,
  output logic             enter_rej,
  output logic [CTR_W-1:0] fail_cnt
);

  ch_state_e        state_q, state_d;
  logic [CTR_W-1:0] hold_q, hold_d;
  logic [CTR_W-1:0] fail_q, fail_d;

  // State, hold and fail registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      hold_q  <= {CTR_W{1'b0}};
      fail_q  <= {CTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fail_q  <= fail_d;
    end
  end

  // Next state: hold_q counts the verdict cycles still to go after this one.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (ena) begin
      case (state_q)
        CH_IDLE: begin
          if (prod && start_ok) begin
            state_d = CH_INSPECT;
          end else begin
            state_d = CH_IDLE;
          end
        end
        CH_INSPECT: begin
          hold_d = CTR_W'(HOLD_CYCLES - 1);
          if (ri) begin
            state_d = CH_PASS;
          end else begin
            state_d = CH_REJECT;
          end
        end
        CH_PASS, CH_REJECT: begin
          if (hold_q == {CTR_W{1'b0}}) begin
            state_d = CH_IDLE;
          end else begin
            hold_d = hold_q - {{(CTR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = CH_IDLE;
          hold_d  = {CTR_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      hold_d  = hold_q;
    end
  end

  // Outputs: verdict code and one-cycle entry strobes for the statistics.
  always_comb begin
    state      = state_q;
    enter_pass = ena && (state_q == CH_INSPECT) && ri;
    enter_rej  = ena && (state_q == CH_INSPECT) && !ri;
  end

  // Consecutive-reject counter; an operator restart clears it over any entry.
  always_comb begin
    fail_d = fail_q;
    if (!ena) begin
      fail_d = fail_q;
    end else if (fail_clr) begin
      fail_d = {CTR_W{1'b0}};
    end else if (enter_rej) begin
      if (fail_q == CTR_W'(FAIL_LIMIT)) begin
        fail_d = fail_q;
      end else begin
        fail_d = fail_q + {{(CTR_W-1){1'b0}}, 1'b1};
      end
    end else if (enter_pass) begin
      fail_d = {CTR_W{1'b0}};
    end else begin
      fail_d = fail_q;
    end
  end

  assign fail_cnt = fail_q;

endmodule

// File: rtl/quality_inspect_ctrl.sv
// Quality inspection controller: N_CH inspection channels, a RUN/WARN/STOP
// line protocol FSM and saturating pass/reject statistics.
module quality_inspect_ctrl
  import quality_inspect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int FAIL_LIMIT  = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_CH-1:0]   prod,
  input  logic [N_CH-1:0]   ri,
  input  logic              clr_alarm,
  input  logic              cnt_clr,
  output logic [2*N_CH-1:0] E,
  output logic [1:0]        Y,
  output logic              line_stop,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  rej_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  prot_state_e             prot_q, prot_d;
  logic                    armed_q, armed_d;
  logic [CNT_W-1:0]        pass_q, pass_d;
  logic [CNT_W-1:0]        rej_q, rej_d;
  logic [N_CH-1:0][1:0]    ch_state_s;
  logic [N_CH-1:0][CTR_W-1:0] ch_fail_s;
  logic [N_CH-1:0]         ent_pass_s, ent_rej_s;
  logic                    stopped_s, start_ok_s, fail_clr_s;
  logic                    limit_hit_s, any_fail_s;
  logic [7:0]              ent_pass8_s, ent_rej8_s;
  logic [CNT_W+3:0]        pass_sum_s, rej_sum_s;

  assign stopped_s  = (prot_q == PR_STOP);
  // armed_q keeps the first edge after reset release from starting an inspection.
  assign start_ok_s = armed_q && !stopped_s;
  assign fail_clr_s = ena && stopped_s && clr_alarm;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      inspect_channel #(
        .FAIL_LIMIT (FAIL_LIMIT),
        .HOLD_CYCLES(HOLD_CYCLES)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start_ok  (start_ok_s),
        .prod      (prod[g]),
        .ri        (ri[g]),
        .fail_clr  (fail_clr_s),
        .state     (ch_state_s[g]),
        .enter_pass(ent_pass_s[g]),
        .enter_rej (ent_rej_s[g]),
        .fail_cnt  (ch_fail_s[g])
      );
    end
  endgenerate

  // Reduce the registered fail counters to the two protocol conditions.
  always_comb begin
    limit_hit_s = 1'b0;
    any_fail_s  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_fail_s[i] == CTR_W'(FAIL_LIMIT)) begin
        limit_hit_s = 1'b1;
      end else begin
        limit_hit_s = limit_hit_s;
      end
      if (ch_fail_s[i] != {CTR_W{1'b0}}) begin
        any_fail_s = 1'b1;
      end else begin
        any_fail_s = any_fail_s;
      end
    end
  end

  // Protocol, arming and statistics registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot_q  <= PR_RUN;
      armed_q <= 1'b0;
      pass_q  <= {CNT_W{1'b0}};
      rej_q   <= {CNT_W{1'b0}};
    end else begin
      prot_q  <= prot_d;
      armed_q <= armed_d;
      pass_q  <= pass_d;
      rej_q   <= rej_d;
    end
  end

  // Protocol next state; everything freezes while ena is low.
  always_comb begin
    prot_d  = prot_q;
    armed_d = armed_q;
    if (ena) begin
      armed_d = 1'b1;
      case (prot_q)
        PR_RUN: begin
          if (limit_hit_s) begin
            prot_d = PR_STOP;
          end else if (any_fail_s) begin
            prot_d = PR_WARN;
          end else begin
            prot_d = PR_RUN;
          end
        end
        PR_WARN: begin
          if (limit_hit_s) begin
            prot_d = PR_STOP;
          end else if (!any_fail_s) begin
            prot_d = PR_RUN;
          end else begin
            prot_d = PR_WARN;
          end
        end
        PR_STOP: begin
          if (clr_alarm) begin
            prot_d = PR_RUN;
          end else begin
            prot_d = PR_STOP;
          end
        end
        default: prot_d = PR_RUN;
      endcase
    end else begin
      prot_d  = prot_q;
      armed_d = armed_q;
    end
  end

  // Mealy protocol outputs and gated verdict codes.
  always_comb begin
    Y         = Y_RUN;
    line_stop = 1'b0;
    E         = {(2*N_CH){1'b0}};
    if (ena) begin
      line_stop = stopped_s;
      for (int i = 0; i < N_CH; i++) begin
        E[2*i +: 2] = ch_state_s[i];
      end
      case (prot_q)
        PR_RUN:  Y = limit_hit_s ? Y_STOP : Y_RUN;
        PR_WARN: Y = limit_hit_s ? Y_STOP : Y_WARN;
        PR_STOP: Y = clr_alarm ? Y_RESTART : Y_STOP;
        default: Y = Y_RUN;
      endcase
    end else begin
      Y         = Y_RUN;
      line_stop = 1'b0;
      E         = {(2*N_CH){1'b0}};
    end
  end

  // Saturating statistics; a clear beats a same-edge increment.
  always_comb begin
    ent_pass8_s = 8'h00;
    ent_rej8_s  = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      ent_pass8_s[i] = ent_pass_s[i];
      ent_rej8_s[i]  = ent_rej_s[i];
    end
    pass_sum_s = (CNT_W+4)'(pass_q) + (CNT_W+4)'(popcount8(ent_pass8_s));
    rej_sum_s  = (CNT_W+4)'(rej_q) + (CNT_W+4)'(popcount8(ent_rej8_s));
    pass_d = pass_q;
    rej_d  = rej_q;
    if (!ena) begin
      pass_d = pass_q;
      rej_d  = rej_q;
    end else if (cnt_clr) begin
      pass_d = {CNT_W{1'b0}};
      rej_d  = {CNT_W{1'b0}};
    end else begin
      if (pass_sum_s > (CNT_W+4)'(CNT_MAX)) begin
        pass_d = CNT_MAX;
      end else begin
        pass_d = pass_sum_s[CNT_W-1:0];
      end
      if (rej_sum_s > (CNT_W+4)'(CNT_MAX)) begin
        rej_d = CNT_MAX;
      end else begin
        rej_d = rej_sum_s[CNT_W-1:0];
      end
    end
  end

  assign pass_cnt = pass_q;
  assign rej_cnt  = rej_q;

endmodule

// File: tb/tb_quality_inspect_ctrl.sv
// Self-checking bench for quality_inspect_ctrl (N_CH=4, FAIL_LIMIT=3,
// HOLD_CYCLES=2, CNT_W=8): hand-derived vector table, corner sequences and
// randomized traffic against a behavioural model.
module tb_quality_inspect_ctrl;

  localparam int N  = 4;
  localparam int FL = 3;
  localparam int HC = 2;
  localparam int CW = 8;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [N-1:0]  prod = '0;
  logic [N-1:0]  ri = '0;
  logic          clr_alarm = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [2*N-1:0] E;
  logic [1:0]    Y;
  logic          line_stop;
  logic [CW-1:0] pass_cnt, rej_cnt;

  quality_inspect_ctrl #(.N_CH(N), .FAIL_LIMIT(FL), .HOLD_CYCLES(HC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .prod(prod), .ri(ri),
    .clr_alarm(clr_alarm), .cnt_clr(cnt_clr), .E(E), .Y(Y),
    .line_stop(line_stop), .pass_cnt(pass_cnt), .rej_cnt(rej_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 inspecting, 2 showing pass, 3 showing reject
  int m_phase[N];
  int m_left[N];     // verdict cycles remaining including the current one
  int m_fails[N];    // consecutive rejects, capped at FL
  int m_prot;        // 0 run, 1 warn, 2 stop
  int m_pass, m_rej;
  bit m_armed;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_left[i] = 0; m_fails[i] = 0;
    end
    m_prot = 0; m_pass = 0; m_rej = 0; m_armed = 1'b0;
  endfunction

  function automatic bit m_limit();
    bit h = 1'b0;
    for (int i = 0; i < N; i++) if (m_fails[i] == FL) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_anyfail();
    bit h = 1'b0;
    for (int i = 0; i < N; i++) if (m_fails[i] != 0) h = 1'b1;
    return h;
  endfunction

  function automatic logic [7:0] m_E(input bit en);
    logic [7:0] e = 8'h00;
    if (en) for (int i = 0; i < N; i++) e[2*i +: 2] = 2'(m_phase[i]);
    return e;
  endfunction

  function automatic logic [1:0] m_Y(input bit en, input bit ca);
    if (!en) return 2'd0;
    if (m_prot == 2) return ca ? 2'd3 : 2'd2;
    if (m_limit()) return 2'd2;
    return (m_prot == 1) ? 2'd1 : 2'd0;
  endfunction

  function automatic void model_step(input bit en, input logic [N-1:0] p, input logic [N-1:0] r,
                                     input bit ca, input bit cc);
    bit lim, anyf, restart;
    int np = 0, nr = 0;
    if (!en) return;
    lim = m_limit(); anyf = m_anyfail();
    restart = (m_prot == 2) && ca;
    for (int i = 0; i < N; i++) begin
      if (m_phase[i] == 0) begin
        if (p[i] && m_prot != 2 && m_armed) m_phase[i] = 1;
      end else if (m_phase[i] == 1) begin
        m_left[i] = HC;
        if (r[i]) begin
          m_phase[i] = 2; np++;
          if (!restart) m_fails[i] = 0;
        end else begin
          m_phase[i] = 3; nr++;
          if (!restart) m_fails[i] = (m_fails[i] + 1 > FL) ? FL : m_fails[i] + 1;
        end
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) m_phase[i] = 0;
      end
      if (restart) m_fails[i] = 0;
    end
    if (m_prot == 2) m_prot = ca ? 0 : 2;
    else if (lim) m_prot = 2;
    else if (m_prot == 0 && anyf) m_prot = 1;
    else if (m_prot == 1 && !anyf) m_prot = 0;
    if (cc) begin
      m_pass = 0; m_rej = 0;
    end else begin
      m_pass = (m_pass + np > CMAX) ? CMAX : m_pass + np;
      m_rej  = (m_rej + nr > CMAX) ? CMAX : m_rej + nr;
    end
    m_armed = 1'b1;
  endfunction

  // One clock: drive at the negedge, compare with the model, advance.
  task automatic cyc(input bit en, input logic [N-1:0] p, input logic [N-1:0] r,
                     input bit ca, input bit cc);
    ena = en; prod = p; ri = r; clr_alarm = ca; cnt_clr = cc;
    #1;
    check("model_E", E, m_E(en));
    check("model_Y", Y, m_Y(en, ca));
    check("model_line_stop", line_stop, en && (m_prot == 2));
    check("model_pass_cnt", pass_cnt, m_pass);
    check("model_rej_cnt", rej_cnt, m_rej);
    model_step(en, p, r, ca, cc);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en; logic [3:0] p; logic [3:0] r; bit ca; bit cc;
    logic [7:0] e; logic [1:0] y; bit ls; logic [7:0] pc; logic [7:0] rc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // first edge after release ignored, then ch0 pass held two cycles
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0, 8'd0});
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0, 8'd0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0, 8'd0, 8'd0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 8'd1, 8'd0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 8'd1, 8'd0});
    // ch0/ch3 pass, ch1 rejects on one edge
    tbl.push_back('{1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd1, 8'd0});
    tbl.push_back('{1'b1, 4'b0000, 4'b1001, 1'b0, 1'b0, 8'h45, 2'd0, 1'b0, 8'd1, 8'd0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h8E, 2'd0, 1'b0, 8'd3, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h8E, 2'd1, 1'b0, 8'd3, 8'd1});
    // ch1 passes: fail counter clears, WARN returns to RUN
    tbl.push_back('{1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 8'd3, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'h04, 2'd1, 1'b0, 8'd3, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h08, 2'd1, 1'b0, 8'd4, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h08, 2'd0, 1'b0, 8'd4, 8'd1});
    // three rejects on ch2
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd4, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 2'd0, 1'b0, 8'd4, 8'd1});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd0, 1'b0, 8'd4, 8'd2});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd1, 1'b0, 8'd4, 8'd2});
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 8'd4, 8'd2});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 2'd1, 1'b0, 8'd4, 8'd2});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd1, 1'b0, 8'd4, 8'd3});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd1, 1'b0, 8'd4, 8'd3});
    tbl.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 8'd4, 8'd3});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10, 2'd1, 1'b0, 8'd4, 8'd3});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h30, 2'd2, 1'b0, 8'd4, 8'd4});
    // STOP: new products ignored
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h30, 2'd2, 1'b1, 8'd4, 8'd4});
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd2, 1'b1, 8'd4, 8'd4});
    // restart, then clr_alarm in RUN has no effect
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd3, 1'b1, 8'd4, 8'd4});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'd4, 8'd4});
    // ena low for five cycles in the middle of a PASS
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd4, 8'd4});
    tbl.push_back('{1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'h01, 2'd0, 1'b0, 8'd4, 8'd4});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 8'd5, 8'd4});
    // statistics clear
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00, 2'd0, 1'b0, 8'd5, 8'd4});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0, 8'd0});
  end

  // ---------------- test sequence ----------------
  initial begin
    #1;
    model_reset();
    @(negedge clk);
    ena = 1'b1;
    #1;
    check("reset_E", E, 8'h00);
    check("reset_Y", Y, 2'd0);
    check("reset_line_stop", line_stop, 1'b0);
    check("reset_pass_cnt", pass_cnt, 8'd0);
    check("reset_rej_cnt", rej_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven directed vectors
    for (int k = 0; k < tbl.size(); k++) begin
      ena = tbl[k].en; prod = tbl[k].p; ri = tbl[k].r;
      clr_alarm = tbl[k].ca; cnt_clr = tbl[k].cc;
      #1;
      check($sformatf("tbl%0d_E", k), E, tbl[k].e);
      check($sformatf("tbl%0d_Y", k), Y, tbl[k].y);
      check($sformatf("tbl%0d_line_stop", k), line_stop, tbl[k].ls);
      check($sformatf("tbl%0d_pass_cnt", k), pass_cnt, tbl[k].pc);
      check($sformatf("tbl%0d_rej_cnt", k), rej_cnt, tbl[k].rc);
      cyc(tbl[k].en, tbl[k].p, tbl[k].r, tbl[k].ca, tbl[k].cc);
    end

    // pass counter saturation, then clear colliding with an increment
    for (int k = 0; k < 4 * 66; k++) cyc(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #1;
    check("sat_pass_cnt", pass_cnt, 8'd255);
    cyc(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
    #1;
    check("clr_beats_inc_pass_cnt", pass_cnt, 8'd0);
    repeat (3) cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // reset asserted in the middle of a REJECT verdict
    cyc(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrej_reset_E", E, 8'h00);
    check("midrej_reset_Y", Y, 2'd0);
    check("midrej_reset_line_stop", line_stop, 1'b0);
    check("midrej_reset_pass_cnt", pass_cnt, 8'd0);
    check("midrej_reset_rej_cnt", rej_cnt, 8'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    cyc(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    #1;
    check("post_reset_second_edge_E", E, 8'h01);
    repeat (4) cyc(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 10) != 0, 4'($urandom), 4'($urandom),
          ($urandom % 6) == 0, ($urandom % 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
